conv2d_stride: RTL and testbench
================================

# conv2d_stride

- Forward strided 2-D convolution engine: the downsampling counterpart of the team's transposed-convolution (deconv) block.
- Loads a K×K kernel and an M×M image through the same strobe/pixel-number interface as the deconv block, then computes every valid window with one multiply-accumulate per cycle.
- Exposes results through an addressed read port.
- Sits downstream of deconv output, or standalone for encoder-side feature extraction.

## Interface
- M, 6, input image side (pixels)
- K, 3, kernel side
- pixel_bits, 8, pixel/weight/result width (unsigned)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  global enable; low freezes FSM and ignores loads
- strobe_signal  in  1  write kernel_weight to next weight slot
- kernel_weight  in  pixel_bits  weight data
- pixel_write  in  1  write pixel to image slot pixel_number
- pixel  in  pixel_bits  pixel data
- pixel_number  in  $clog2(M*M)  row-major image index
- stride  in  $clog2(K)+1  stride 1..K; 0 treated as 1, >K treated as K
- start  in  1  begin convolution
- result_address  in  $clog2((M-K+1)**2)  row-major output index
- final_output  out  pixel_bits  result at result_address
- out_dim  out  $clog2(M-K+1)+1  output side O for last run
- busy  out  1  computation in progress
- done  out  1  level; results valid

## Operation
- Weight index counter 0..K*K-1; each strobe_signal cycle (enable=1, not busy) writes slot, increments, wraps to 0 after K*K-1.
- pixel_write stores pixel at pixel_number (out-of-range index ignored); loads ignored while busy.
- FSM states: IDLE, MAC, WRITE, FIN.
  - IDLE: start & enable -> latch stride S, clear accumulator, window origin (0,0), tap 0 -> MAC; done cleared.
  - MAC: acc += img[r+i][c+j]*w[i][j], one tap per cycle, taps row-major; after tap K*K-1 -> WRITE.
  - WRITE: store result at output index; advance c by S; if c+S+K > M, c=0 and r+=S; if r overflows -> FIN, else -> MAC with acc cleared.
  - FIN: done=1, busy=0, out_dim=O -> IDLE (done stays high until next start or rst).
- O = floor((M-K)/S)+1, derived by window stepping, no divider.
- Accumulator width 2*pixel_bits+$clog2(K*K); products unsigned.
- Result locations beyond O*O keep prior contents.

## Timing
- Reset: final_output=0, out_dim=0, busy=0, done=0, FSM=IDLE, weight index=0, acc=0, result buffer zeroed. Image/weight memories need not clear.
- busy rises edge after start sampled.
- Per output K*K+1 cycles; done rises O*O*(K*K+1)+1 edges after start edge (enable held high).
- enable low: all state held, cycle count extends by stalled cycles.
- start while busy ignored; start with done high restarts.
- final_output registered: valid one cycle after result_address changes, any state.
- rst mid-run: immediate abort to IDLE, done=0.
- strobe_signal and pixel_write in same cycle: both performed.

## Configuration
- CONV2D_SATURATE_EN defined: result > 2**pixel_bits-1 clamps to all ones.
- Undefined: result truncated to low pixel_bits bits.

## Structure
- conv2d_pkg: FSM state enum, accumulator-width and O_MAX=(M-K+1) constant functions, saturate/truncate function.
- One sub-module conv2d_mac: registered multiply-accumulate with clear and enable.

## Test plan
- M=4,K=3,S=1, all pixels 1, all weights 1 -> out_dim=2, four results 9, done 41 cycles after start.
- M=6,K=3,S=2, pixel[n]=n, identity-centre kernel (w[4]=1, rest 0) -> out_dim=2, results 7,9,19,21.
- Pixels 255, weights 255, S=1, M=4 -> 255 with CONV2D_SATURATE_EN, 9 without.
- enable low 5 cycles mid-run -> done delayed exactly 5 cycles, results unchanged.
- rst pulse mid-MAC -> busy=0, done=0, final_output=0; new start completes correctly.
- Ten weight strobes -> tenth overwrites slot 0; start during busy ignored (done timing unchanged).

Source files
------------

// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the strided 2-D convolution engine.
// CONV2D_SATURATE_EN selects clamping instead of truncation in clip_result.
package conv2d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE,
        ST_FIN
    } state_t;

    function automatic int acc_width(input int pbits, input int k);
        return 2 * pbits + $clog2(k * k);
    endfunction

    function automatic int o_max(input int m, input int k);
        return m - k + 1;
    endfunction

    // Reduce an accumulator value to the pixel range.
    function automatic logic [31:0] clip_result(input logic [31:0] acc, input int pbits);
        logic [31:0] lim;
        lim = (32'd1 << pbits) - 32'd1;
`ifdef CONV2D_SATURATE_EN
        return (acc > lim) ? lim : acc;
`else
        return acc & lim;
`endif
    endfunction

endpackage

// File: rtl/conv2d_mac.sv
// Registered unsigned multiply-accumulate; one product per enabled cycle.
// Clear has priority over enable and zeroes the accumulator on the next edge.
module conv2d_mac #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [2*DW-1:0] prod;

    always_comb begin
        prod  = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv2d_stride.sv
// Strided K x K convolution over an M x M image, one MAC per cycle, results read by address.
// Build with CONV2D_SATURATE_EN to clamp results at all-ones instead of truncating.
module conv2d_stride
    import conv2d_pkg::*;
#(
    parameter int M          = 6,
    parameter int K          = 3,
    parameter int pixel_bits = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            strobe_signal,
    input  logic [pixel_bits-1:0]           kernel_weight,
    input  logic                            pixel_write,
    input  logic [pixel_bits-1:0]           pixel,
    input  logic [$clog2(M*M)-1:0]          pixel_number,
    input  logic [$clog2(K):0]              stride,
    input  logic                            start,
    input  logic [$clog2((M-K+1)**2)-1:0]   result_address,
    output logic [pixel_bits-1:0]           final_output,
    output logic [$clog2(M-K+1):0]          out_dim,
    output logic                            busy,
    output logic                            done
);

    localparam int NPIX     = M * M;
    localparam int NW       = K * K;
    localparam int OMAX     = o_max(M, K);
    localparam int ACC_W    = acc_width(pixel_bits, K);
    localparam int PN_W     = $clog2(NPIX);
    localparam int WI_W     = $clog2(NW);
    localparam int RA_W     = $clog2(OMAX * OMAX);
    localparam int NRES_BUF = 1 << RA_W;
    localparam int OD_W     = $clog2(OMAX) + 1;
    localparam int ST_W     = $clog2(K) + 1;
    localparam int TW       = $clog2(K + 1);
    // Wide enough to hold c + S + K without wrapping.
    localparam int CW       = $clog2(2 * M + 1);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ST_W-1:0]     s_q, s_d;
    logic [CW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    logic [TW-1:0]       ti_q, ti_d;
    logic [TW-1:0]       tj_q, tj_d;
    logic [OD_W-1:0]     oc_q, oc_d;
    logic [RA_W-1:0]     ri_q, ri_d;
    logic [OD_W-1:0]     out_dim_q, out_dim_d;
    logic [WI_W-1:0]     widx_q, widx_d;
    logic [pixel_bits-1:0] fo_q, fo_d;

    logic [pixel_bits-1:0] img_q [NPIX];
    logic [pixel_bits-1:0] w_q   [NW];
    logic [pixel_bits-1:0] res_q [NRES_BUF];

    logic [ST_W-1:0]       s_eff;
    logic [CW-1:0]         c_next;
    logic [CW-1:0]         r_next;
    logic [PN_W-1:0]       img_idx;
    logic [WI_W-1:0]       w_idx;
    logic                  load_ok;
    logic                  w_we;
    logic                  p_we;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  res_we;
    logic [ACC_W-1:0]      mac_acc;
    logic [pixel_bits-1:0] res_dat;

    conv2d_mac #(
        .DW (pixel_bits),
        .AW (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (img_q[img_idx]),
        .b   (w_q[w_idx]),
        .acc (mac_acc)
    );

    always_comb begin
        if (stride == '0) begin
            s_eff = ST_W'(1);
        end else if (stride > ST_W'(K)) begin
            s_eff = ST_W'(K);
        end else begin
            s_eff = stride;
        end
        img_idx = PN_W'(r_q + CW'(ti_q)) * PN_W'(M) + PN_W'(c_q) + PN_W'(tj_q);
        w_idx   = WI_W'(ti_q) * WI_W'(K) + WI_W'(tj_q);
        c_next  = c_q + CW'(s_q);
        r_next  = r_q + CW'(s_q);
        res_dat = pixel_bits'(clip_result(32'(mac_acc), pixel_bits));
    end

    always_comb begin
        load_ok = enable && !busy_q;
        w_we    = load_ok && strobe_signal;
        p_we    = load_ok && pixel_write && (int'(pixel_number) < NPIX);
        widx_d  = widx_q;
        if (w_we) begin
            widx_d = (widx_q == WI_W'(NW - 1)) ? '0 : widx_q + WI_W'(1);
        end
        fo_d = res_q[result_address];
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        s_d       = s_q;
        r_d       = r_q;
        c_d       = c_q;
        ti_d      = ti_q;
        tj_d      = tj_q;
        oc_d      = oc_q;
        ri_d      = ri_q;
        out_dim_d = out_dim_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        res_we    = 1'b0;
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_MAC;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        s_d     = s_eff;
                        r_d     = '0;
                        c_d     = '0;
                        ti_d    = '0;
                        tj_d    = '0;
                        oc_d    = '0;
                        ri_d    = '0;
                        mac_clr = 1'b1;
                    end
                end
                ST_MAC: begin
                    mac_en = 1'b1;
                    if (tj_q == TW'(K - 1)) begin
                        tj_d = '0;
                        if (ti_q == TW'(K - 1)) begin
                            ti_d    = '0;
                            state_d = ST_WRITE;
                        end else begin
                            ti_d = ti_q + TW'(1);
                        end
                    end else begin
                        tj_d = tj_q + TW'(1);
                    end
                end
                ST_WRITE: begin
                    res_we  = 1'b1;
                    mac_clr = 1'b1;
                    state_d = ST_MAC;
                    if (c_next + CW'(K) > CW'(M)) begin
                        // oc_q is left at O-1 on the last window so FIN can report O.
                        if (r_next + CW'(K) > CW'(M)) begin
                            state_d = ST_FIN;
                        end else begin
                            c_d  = '0;
                            r_d  = r_next;
                            oc_d = '0;
                            ri_d = ri_q + RA_W'(1);
                        end
                    end else begin
                        c_d  = c_next;
                        oc_d = oc_q + OD_W'(1);
                        ri_d = ri_q + RA_W'(1);
                    end
                end
                ST_FIN: begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    out_dim_d = oc_q + OD_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            ti_q      <= '0;
            tj_q      <= '0;
            oc_q      <= '0;
            ri_q      <= '0;
            out_dim_q <= '0;
            widx_q    <= '0;
            fo_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_q       <= s_d;
            r_q       <= r_d;
            c_q       <= c_d;
            ti_q      <= ti_d;
            tj_q      <= tj_d;
            oc_q      <= oc_d;
            ri_q      <= ri_d;
            out_dim_q <= out_dim_d;
            widx_q    <= widx_d;
            fo_q      <= fo_d;
        end
    end

    // Image and kernel storage are not reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (w_we) begin
            w_q[widx_q] <= kernel_weight;
        end
        if (p_we) begin
            img_q[pixel_number] <= pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NRES_BUF; i++) begin
                res_q[i] <= '0;
            end
        end else if (res_we) begin
            res_q[ri_q] <= res_dat;
        end
    end

    assign final_output = fo_q;
    assign out_dim      = out_dim_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_conv2d_stride.sv
// Directed bench for conv2d_stride at M=6, K=3, 8-bit pixels.
module tb_conv2d_stride;

    localparam int M = 6;
    localparam int K = 3;

`ifdef CONV2D_SATURATE_EN
    localparam logic [7:0] SATV = 8'd255;
`else
    localparam logic [7:0] SATV = 8'd9;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       strobe_signal;
    logic [7:0] kernel_weight;
    logic       pixel_write;
    logic [7:0] pixel;
    logic [5:0] pixel_number;
    logic [2:0] stride;
    logic       start;
    logic [3:0] result_address;
    logic [7:0] final_output;
    logic [2:0] out_dim;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [2:0]       s;
        logic [2:0]       pmode;
        logic [2:0]       wmode;
        logic [2:0]       dim;
        logic [8:0]       cyc;
        logic [15:0][7:0] res;
    } vec_t;

    conv2d_stride #(.M(M), .K(K), .pixel_bits(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .strobe_signal  (strobe_signal),
        .kernel_weight  (kernel_weight),
        .pixel_write    (pixel_write),
        .pixel          (pixel),
        .pixel_number   (pixel_number),
        .stride         (stride),
        .start          (start),
        .result_address (result_address),
        .final_output   (final_output),
        .out_dim        (out_dim),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int mode, input int n);
        case (mode)
            0:       return 8'd1;
            1:       return 8'(n);
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] w_val(input int mode, input int n);
        case (mode)
            0:       return 8'd1;
            1:       return (n == 4) ? 8'd1 : 8'd0;
            2:       return (n == 0) ? 8'd1 : 8'd0;
            3:       return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    function automatic vec_t mkv(input int s, input int pm, input int wm, input int dim,
                                 input int cyc, input logic [15:0][7:0] res);
        vec_t v;
        v.s     = 3'(s);
        v.pmode = 3'(pm);
        v.wmode = 3'(wm);
        v.dim   = 3'(dim);
        v.cyc   = 9'(cyc);
        v.res   = res;
        return v;
    endfunction

    // Pixel and weight writes share cycles so simultaneous loads are exercised.
    task automatic load(input int pm, input int wm);
        for (int n = 0; n < M * M; n++) begin
            @(negedge clk);
            pixel_write   = 1'b1;
            pixel_number  = 6'(n);
            pixel         = pix_val(pm, n);
            strobe_signal = (n < K * K);
            kernel_weight = w_val(wm, n);
        end
        @(negedge clk);
        pixel_write   = 1'b0;
        strobe_signal = 1'b0;
    endtask

    task automatic run(input logic [2:0] s, input int stall_at, input int restart_at,
                       output int cyc);
        @(negedge clk);
        stride = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == stall_at) enable = 1'b0;
            if (cyc == stall_at + 5) enable = 1'b1;
        end
        start  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic check_res(input logic [15:0][7:0] exp, input int n, input string tag);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            result_address = 4'(a);
            @(negedge clk);
            chk($sformatf("%s res[%0d]", tag, a), int'(final_output), int'(exp[a]));
        end
    endtask

    initial begin
        vec_t             vecs[7];
        logic [15:0][7:0] r;
        int               cyc;

        r = {16{8'd9}};
        vecs[0] = mkv(1, 0, 0, 4, 161, r);
        vecs[1] = mkv(3, 0, 0, 2, 41, r);
        r[0] = 8'd7;  r[1] = 8'd9;  r[2] = 8'd19; r[3] = 8'd21;
        vecs[2] = mkv(2, 1, 1, 2, 41, r);
        for (int a = 0; a < 16; a++) r[a] = 8'(((a / 4) + 1) * M + (a % 4) + 1);
        vecs[3] = mkv(0, 1, 1, 4, 161, r);
        r[0] = 8'd0;  r[1] = 8'd3;  r[2] = 8'd18; r[3] = 8'd21;
        vecs[4] = mkv(7, 1, 2, 2, 41, r);
        r[0] = 8'd63; r[1] = 8'd81; r[2] = 8'd171; r[3] = 8'd189;
        vecs[5] = mkv(2, 1, 0, 2, 41, r);
        r = {16{SATV}};
        vecs[6] = mkv(1, 2, 3, 4, 161, r);

        rst            = 1'b1;
        enable         = 1'b1;
        strobe_signal  = 1'b0;
        kernel_weight  = 8'd0;
        pixel_write    = 1'b0;
        pixel          = 8'd0;
        pixel_number   = 6'd0;
        stride         = 3'd1;
        start          = 1'b0;
        result_address = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset out_dim", int'(out_dim), 0);
        chk("reset final_output", int'(final_output), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load(int'(vecs[i].pmode), int'(vecs[i].wmode));
            run(vecs[i].s, 0, 0, cyc);
            chk($sformatf("vec%0d cycles", i), cyc, int'(vecs[i].cyc));
            chk($sformatf("vec%0d out_dim", i), int'(out_dim), int'(vecs[i].dim));
            chk($sformatf("vec%0d busy_end", i), int'(busy), 0);
            check_res(vecs[i].res, 16, $sformatf("vec%0d", i));
        end

        // Five stalled cycles in the middle of a run.
        load(1, 1);
        run(3'd2, 20, 0, cyc);
        chk("stall cycles", cyc, 46);
        r[0] = 8'd7;  r[1] = 8'd9;  r[2] = 8'd19; r[3] = 8'd21;
        check_res(r, 4, "stall");

        // Reset while MAC is in progress.
        load(0, 0);
        @(negedge clk);
        stride = 3'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst out_dim", int'(out_dim), 0);
        chk("midrst final_output", int'(final_output), 0);
        @(negedge clk);
        rst = 1'b0;
        r = '0;
        check_res(r, 2, "postrst_zero");
        run(3'd1, 0, 0, cyc);
        chk("postrst cycles", cyc, 161);
        chk("postrst out_dim", int'(out_dim), 4);
        r = {16{8'd9}};
        check_res(r, 16, "postrst");

        // Tenth strobe wraps to slot 0; a start while busy must not disturb the run.
        load(1, 4);
        @(negedge clk);
        strobe_signal = 1'b1;
        kernel_weight = 8'd1;
        @(negedge clk);
        strobe_signal = 1'b0;
        run(3'd2, 0, 10, cyc);
        chk("wrap cycles", cyc, 41);
        chk("wrap out_dim", int'(out_dim), 2);
        r[0] = 8'd0;  r[1] = 8'd2;  r[2] = 8'd12; r[3] = 8'd14;
        check_res(r, 4, "wrap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
